dff_shift_reg: RTL and testbench
================================

Name: dff_shift_reg

Overview:
Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit universal register with enable, parallel load, logical shift, rotate, clear and invert modes. It also provides true and complement outputs, serial taps, and a shift counter that flags each completed WIDTH-shift frame. It is the team's standard storage/serialiser element for datapaths and serial links.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 = hold everything
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin  input  1  serial input for shift modes
q  output  WIDTH  registered contents
qbar  output  WIDTH  bitwise complement of q
sout_msb  output  1  q[WIDTH-1]
sout_lsb  output  1  q[0]
frame_done  output  1  one-cycle pulse when a WIDTH-shift frame completes

Behaviour:
- Reset:
  - Asynchronous and active-low: clock is one, `clk`; reset is asynchronous, active-low, named `rst_n`.
  - While rst_n=0: q=RESET_VAL, qbar=~RESET_VAL, cnt=0, frame_done=0. Reset takes effect immediately, independent of clk.
  - Deassertion is synchronised externally.
- qbar, sout_msb, sout_lsb:
  - Pure combinational functions of q, valid in the same cycle as q.
  - There is no one-cycle lag on qbar: qbar == ~q at all times, including during reset.
- Internal cnt:
  - Width max(1, $clog2(WIDTH)).
  - Counts shift/rotate operations since the last load/clear/reset.
- Operations, evaluated on posedge clk when en=1:
  - 000 HOLD: q and cnt unchanged.
  - 001 LOAD: q<=d; cnt<=0.
  - 010 SHL: q<={q[WIDTH-2:0],sin}; count.
  - 011 SHR: q<={sin,q[WIDTH-1:1]}; count.
  - 100 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}; count.
  - 101 ROR: q<={q[0],q[WIDTH-1:1]}; count.
  - 110 CLR: q<=0; cnt<=0.
  - 111 INV: q<=~q; cnt unchanged.
- Counting rule, for "count" operations:
  - If cnt==WIDTH-1: cnt<=0 and frame_done<=1.
  - Otherwise: cnt<=cnt+1 and frame_done<=0.
- frame_done:
  - Registered; rises on the same edge that updates q with the WIDTH-th shift.
  - Forced to 0 on every edge that is not a wrapping count, including when en=0.
- en=0: q and cnt hold; frame_done<=0.
- Mixed shift/rotate directions all advance the same counter.
- Latency: one clock from input to q for all modes; zero from q to qbar/taps.
- Reset asserted mid-frame: aborts the frame; cnt=0 and no frame_done pulse is produced.
- LOAD or CLR mid-frame: restarts the count from 0; no pulse.
- Inputs d/sin/mode are don't-care when en=0 or rst_n=0.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle (WIDTH=8, RESET_VAL=0) -> q=0x00, qbar=0xFF, frame_done=0 immediately, before any clk edge.
- Load: en=1, mode=001, d=0xA5 -> next cycle q=0xA5, qbar=0x5A, sout_msb=1, sout_lsb=1.
- Shift left: from 0xA5, SHL with sin=1 -> q=0x4B. Continue SHL sin=1 for 7 more cycles -> q=0xFF after the 8th shift, frame_done=1 for exactly that cycle, 0 on the following cycle.
- Rotate right: from 0xA5, ROR -> q=0xD2. Then INV -> q=0x2D with cnt unchanged. Further ROR x7 -> frame_done pulses on the 8th total rotate.
- Enable gating: from q=0x3C, en=0 with mode=010 for 5 cycles -> q stays 0x3C, frame_done stays 0, cnt unchanged (verify by completing the frame afterwards in exactly the remaining count).
- Abort cases: 4 SHL, then LOAD 0x00, then 7 SHL -> no frame_done; the 8th SHL pulses it. Repeat with rst_n pulsed after 5 shifts -> q=RESET_VAL, the subsequent frame needs a full 8 shifts.

Source files
------------

// File: rtl/dff_shift_reg.sv
// dff_shift_reg: WIDTH-bit universal register with hold, parallel load,
// logical shift, rotate, clear and invert modes. It provides true and
// complement outputs, serial taps and a frame pulse after every WIDTH
// shift/rotate operations.
module dff_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             frame_done
);

  // WIDTH >= 2, so $clog2 is always at least 1.
  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_INV  = 3'b111;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_nxt;
  logic             is_count;
  logic             is_restart;
  logic             wrap;

  // Next register value and operation class for the selected mode.
  always_comb begin
    q_nxt      = q;
    is_count   = 1'b0;
    is_restart = 1'b0;
    case (mode)
      M_HOLD: q_nxt = q;
      M_LOAD: begin
        q_nxt      = d;
        is_restart = 1'b1;
      end
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        is_count = 1'b1;
      end
      M_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        is_count = 1'b1;
      end
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        is_count = 1'b1;
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        is_count = 1'b1;
      end
      M_CLR: begin
        q_nxt      = '0;
        is_restart = 1'b1;
      end
      M_INV: q_nxt = ~q;
      default: q_nxt = q;
    endcase
  end

  // A frame completes on the enabled shift/rotate that finds the counter at its last value.
  assign wrap = en && is_count && (cnt == CNT_LAST);

  // Register, shift counter and frame pulse; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        q <= q_nxt;
        if (is_restart) begin
          cnt <= '0;
        end else if (is_count) begin
          cnt <= wrap ? '0 : cnt + CW'(1);
        end
      end
    end
  end

  // Complement and taps follow q combinationally, with no lag.
  assign qbar     = ~q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_dff_shift_reg.sv
// Directed testbench for dff_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_dff_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         sout_msb;
  logic         sout_lsb;
  logic         frame_done;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, CLR = 3'b110, INV = 3'b111;

  dff_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .d          (d),
    .sin        (sin),
    .q          (q),
    .qbar       (qbar),
    .sout_msb   (sout_msb),
    .sout_lsb   (sout_lsb),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1ns past it.
  task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] dd, input logic s);
    en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = HOLD; d = '0; sin = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_fd", frame_done, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_q", q, 8'h00);
    #2 rst_n = 1'b1;
    #1;

    // Parallel load with taps.
    step(1'b1, LOAD, 8'hA5, 1'b0);
    chk("load_q", q, 8'hA5);
    chk("load_qbar", qbar, 8'h5A);
    chk("load_msb", sout_msb, 1'b1);
    chk("load_lsb", sout_lsb, 1'b1);
    chk("load_fd", frame_done, 1'b0);

    // Shift left with sin=1: frame pulse on the 8th shift only.
    step(1'b1, SHL, 8'h00, 1'b1);
    chk("shl1_q", q, 8'h4B);
    chk("shl1_fd", frame_done, 1'b0);
    step(1'b1, SHL, 8'h00, 1'b1);
    chk("shl2_q", q, 8'h97);
    for (int i = 3; i <= 7; i++) begin
      step(1'b1, SHL, 8'h00, 1'b1);
      chk("shl_mid_fd", frame_done, 1'b0);
    end
    chk("shl7_q", q, 8'hFF);
    step(1'b1, SHL, 8'h00, 1'b1);
    chk("shl8_q", q, 8'hFF);
    chk("shl8_fd", frame_done, 1'b1);
    step(1'b1, HOLD, 8'h00, 1'b0);
    chk("shl_after_fd", frame_done, 1'b0);
    chk("hold_q", q, 8'hFF);

    // Rotate right, invert keeps count, pulse on 8th rotate.
    step(1'b1, LOAD, 8'hA5, 1'b0);
    step(1'b1, ROR, 8'h00, 1'b0);
    chk("ror1_q", q, 8'hD2);
    step(1'b1, INV, 8'h00, 1'b0);
    chk("inv_q", q, 8'h2D);
    chk("inv_fd", frame_done, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step(1'b1, ROR, 8'h00, 1'b0);
      chk("ror_mid_fd", frame_done, 1'b0);
    end
    step(1'b1, ROR, 8'h00, 1'b0);
    chk("ror8_fd", frame_done, 1'b1);
    chk("ror8_q", q, 8'h5A);

    // ROL and SHR data paths (counts are discarded by the next load).
    step(1'b1, LOAD, 8'h81, 1'b0);
    step(1'b1, ROL, 8'h00, 1'b0);
    chk("rol_q", q, 8'h03);
    step(1'b1, LOAD, 8'h81, 1'b0);
    step(1'b1, SHR, 8'h00, 1'b0);
    chk("shr_q", q, 8'h40);
    step(1'b1, SHR, 8'h00, 1'b1);
    chk("shr_sin_q", q, 8'hA0);

    // Enable gating mid-frame: q, cnt hold; frame finishes after the remaining 5.
    step(1'b1, LOAD, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, SHL, 8'h00, 1'b0);
    chk("gate_pre_q", q, 8'hE0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, SHL, 8'hFF, 1'b1);
      chk("gate_q", q, 8'hE0);
      chk("gate_fd", frame_done, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SHL, 8'h00, 1'b0);
      chk("gate_rem_fd", frame_done, 1'b0);
    end
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("gate_last_fd", frame_done, 1'b1);
    step(1'b0, SHL, 8'h00, 1'b0);
    chk("gate_en0_fd", frame_done, 1'b0);

    // LOAD mid-frame restarts the count.
    step(1'b1, LOAD, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, SHL, 8'h00, 1'b1);
    chk("ab_load_pre_q", q, 8'h0F);
    step(1'b1, LOAD, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, SHL, 8'h00, 1'b0);
      chk("ab_load_fd", frame_done, 1'b0);
    end
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("ab_load_last_fd", frame_done, 1'b1);

    // CLR mid-frame clears q and restarts the count.
    step(1'b1, LOAD, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, SHL, 8'h00, 1'b0);
    step(1'b1, CLR, 8'hFF, 1'b1);
    chk("clr_q", q, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, SHL, 8'h00, 1'b0);
      chk("ab_clr_fd", frame_done, 1'b0);
    end
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("ab_clr_last_fd", frame_done, 1'b1);

    // Reset mid-frame aborts it; next frame needs a full 8 shifts.
    step(1'b1, LOAD, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, SHL, 8'h00, 1'b1);
    chk("ab_rst_pre_q", q, 8'h1F);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_rst_q", q, 8'h00);
    chk("ab_rst_qbar", qbar, 8'hFF);
    chk("ab_rst_fd", frame_done, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, SHL, 8'h00, 1'b1);
      chk("ab_rst_fd_mid", frame_done, 1'b0);
    end
    step(1'b1, SHL, 8'h00, 1'b1);
    chk("ab_rst_last_fd", frame_done, 1'b1);
    chk("ab_rst_last_q", q, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
